blur_engine: RTL



---
 rtl/blur_engine_pkg.sv | 18 +
 rtl/blur_line_buffer.sv | 53 +++++
 rtl/blur_engine.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/blur_engine_pkg.sv
// Shared definitions for the blur stage: controller states, binomial kernel
// weights and the rounding applied to the weighted sum.
package blur_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } blur_state_e;

    localparam int unsigned K_CORNER    = 32'd1;
    localparam int unsigned K_EDGE      = 32'd2;
    localparam int unsigned K_CENTRE    = 32'd4;
    localparam int unsigned ROUND_ADD   = 32'd8;
    localparam int unsigned ROUND_SHIFT = 32'd4;

endpackage

// File: rtl/blur_line_buffer.sv
// Circular line delay of DEPTH pixels; the read returns the value written DEPTH
// pushes ago, before this cycle's push overwrites it.
module blur_line_buffer
#(
    parameter int DEPTH = 321,
    parameter int PIX_W = 8
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [PIX_W-1:0] din_i,
    output logic [PIX_W-1:0] dout_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [PIX_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    ptr_d;

    // Pointer advance with wrap at the end of the line.
    always_comb begin
        if (clr_i) begin
            ptr_d = {PW{1'b0}};
        end else if (push_i) begin
            ptr_d = (ptr_q == PTR_LAST) ? {PW{1'b0}} : ptr_q + PW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= {PW{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Storage array, written at the slot that is being read this cycle.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[ptr_q] <= din_i;
        end
    end

    assign dout_o = mem_q[ptr_q];

endmodule

// File: rtl/blur_engine.sv
// 3x3 binomial blur: scans the source frame over a one-pixel-padded grid, keeps
// a sliding window fed by two line buffers, and writes centres in raster order.
module blur_engine
    import blur_engine_pkg::*;
#(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 17
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              blur_start,
    output logic              blur_done,
    output logic              busy,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [PIX_W-1:0]  src_data,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [PIX_W-1:0]  dst_data,
    output logic              dst_we
);

    localparam int XW    = $clog2(IMG_W + 1);
    localparam int YW    = $clog2(IMG_H + 1);
    localparam int SUM_W = PIX_W + int'(ROUND_SHIFT);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H);
    localparam logic [XW-1:0] X_MAXI = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAXI = YW'(IMG_H - 1);

    blur_state_e       state_q;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic              drain_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] src_addr_q;
    logic [XW-1:0]     xb_q;
    logic [YW-1:0]     yb_q;
    logic              vb_q;

    logic              start_s;
    logic              real_b_s;
    logic              wr_s;
    logic              int_s;
    logic [PIX_W-1:0]  pix_s;
    logic [PIX_W-1:0]  row1_s;
    logic [PIX_W-1:0]  row0_s;
    logic [PIX_W-1:0]  win_q [3][3];
    logic [PIX_W-1:0]  win_d [3][3];
    logic [SUM_W-1:0]  corner_s;
    logic [SUM_W-1:0]  edge_s;
    logic [SUM_W-1:0]  sum_s;
    logic [PIX_W-1:0]  kern_s;

    logic [ADDR_W-1:0] wr_cnt_q;
    logic [ADDR_W-1:0] dst_addr_q;
    logic [PIX_W-1:0]  dst_data_q;
    logic              dst_we_q;

    assign start_s = (state_q == ST_IDLE) && blur_start;

    // Controller: state, scan coordinates, read address and the coordinate tag
    // that travels alongside the read into the data stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            x_q        <= {XW{1'b0}};
            y_q        <= {YW{1'b0}};
            drain_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            src_addr_q <= {ADDR_W{1'b0}};
            xb_q       <= {XW{1'b0}};
            yb_q       <= {YW{1'b0}};
            vb_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            vb_q   <= (state_q == ST_SCAN);
            xb_q   <= x_q;
            yb_q   <= y_q;
            case (state_q)
                ST_IDLE: begin
                    if (blur_start) begin
                        state_q    <= ST_SCAN;
                        x_q        <= {XW{1'b0}};
                        y_q        <= {YW{1'b0}};
                        drain_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        src_addr_q <= {ADDR_W{1'b0}};
                    end
                end
                ST_SCAN: begin
                    // Padding coordinates issue no read, so the address holds.
                    if ((x_q < X_LAST) && (y_q < Y_LAST)) begin
                        src_addr_q <= src_addr_q + ADDR_W'(1);
                    end
                    if (x_q == X_LAST) begin
                        x_q <= {XW{1'b0}};
                        if (y_q == Y_LAST) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            y_q <= y_q + YW'(1);
                        end
                    end else begin
                        x_q <= x_q + XW'(1);
                    end
                end
                ST_DRAIN: begin
                    drain_q <= 1'b1;
                    if (drain_q) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign real_b_s = (xb_q < X_LAST) && (yb_q < Y_LAST);

    // Incoming pixel, forced to zero on the padding row and column.
    always_comb begin
        if (vb_q && real_b_s) begin
            pix_s = src_data;
        end else begin
            pix_s = {PIX_W{1'b0}};
        end
    end

    blur_line_buffer #(.DEPTH(IMG_W + 1), .PIX_W(PIX_W)) u_lb0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (start_s),
        .push_i (vb_q),
        .din_i  (pix_s),
        .dout_o (row1_s)
    );

    blur_line_buffer #(.DEPTH(IMG_W + 1), .PIX_W(PIX_W)) u_lb1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (start_s),
        .push_i (vb_q),
        .din_i  (row1_s),
        .dout_o (row0_s)
    );

    // Next window: columns shift left, the new column is rows y-2, y-1, y.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_d[r][c] = win_q[r][c];
            end
        end
        if (vb_q) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = row0_s;
            win_d[1][2] = row1_s;
            win_d[2][2] = pix_s;
        end else begin
            win_d[1][1] = win_q[1][1];
        end
    end

    // Weighted sum of the next window and its rounded average.
    always_comb begin
        corner_s = SUM_W'(win_d[0][0]) + SUM_W'(win_d[0][2])
                 + SUM_W'(win_d[2][0]) + SUM_W'(win_d[2][2]);
        edge_s   = SUM_W'(win_d[0][1]) + SUM_W'(win_d[1][0])
                 + SUM_W'(win_d[1][2]) + SUM_W'(win_d[2][1]);
        sum_s    = SUM_W'(K_CORNER) * corner_s + SUM_W'(K_EDGE) * edge_s
                 + SUM_W'(K_CENTRE) * SUM_W'(win_d[1][1]);
        kern_s   = PIX_W'((sum_s + SUM_W'(ROUND_ADD)) >> ROUND_SHIFT);
    end

    assign wr_s  = vb_q && (xb_q >= XW'(1)) && (yb_q >= YW'(1));
    assign int_s = (xb_q >= XW'(2)) && (xb_q <= X_MAXI)
                && (yb_q >= YW'(2)) && (yb_q <= Y_MAXI);

    // Window registers and the registered destination write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= {PIX_W{1'b0}};
                end
            end
            dst_we_q   <= 1'b0;
            dst_addr_q <= {ADDR_W{1'b0}};
            dst_data_q <= {PIX_W{1'b0}};
            wr_cnt_q   <= {ADDR_W{1'b0}};
        end else begin
            win_q    <= win_d;
            dst_we_q <= wr_s;
            if (start_s) begin
                wr_cnt_q <= {ADDR_W{1'b0}};
            end else if (wr_s) begin
                dst_addr_q <= wr_cnt_q;
                dst_data_q <= int_s ? kern_s : win_d[1][1];
                wr_cnt_q   <= wr_cnt_q + ADDR_W'(1);
            end
        end
    end

    assign blur_done = done_q;
    assign busy      = busy_q;
    assign src_addr  = src_addr_q;
    assign dst_addr  = dst_addr_q;
    assign dst_data  = dst_data_q;
    assign dst_we    = dst_we_q;

endmodule
